// File: rtl/pe_reducer_scheduler.sv
// Packs non-zero (address, weight, activation) entries into LANES-wide bundles for the
// PE reducer, issues a start pulse per bundle and signals tile completion upstream.
//
// state | meaning
// FILL  | accepting entries into the bundle under construction
// ISSUE | one-cycle start pulse, bundle registers frozen
// WAIT  | bundle held until the reducer reports finish
// DONE  | one-cycle tile completion pulse, tile counters cleared on exit
module pe_reducer_scheduler #(
  parameter int LANES     = 3,
  parameter int ADDR_DIMS = 3,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_last,
  input  logic [ADDR_DIMS*ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]                 i_w,
  input  logic [DATA_W-1:0]                 i_ia,
  output logic                              o_pe_start,
  output logic [LANES*ADDR_DIMS*ADDR_W-1:0] o_pe_addr,
  output logic [LANES*DATA_W-1:0]           o_pe_w,
  output logic [LANES*DATA_W-1:0]           o_pe_ia,
  input  logic                              i_pe_finish,
  output logic                              o_tile_done,
  output logic [15:0]                       o_bundle_cnt,
  output logic                              o_busy
);

  localparam int AW = ADDR_DIMS * ADDR_W;
  localparam int IW = $clog2(LANES + 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] fill_idx;
  logic          last_q;
  logic          accept;
  logic          nonzero;
  logic          bundle_full;
  logic          bundle_nonempty;
  logic          clear_bundle;

  assign accept          = i_valid && o_ready;
  assign nonzero         = (i_w != '0) && (i_ia != '0);
  assign bundle_full     = nonzero && (fill_idx == IW'(LANES - 1));
  assign bundle_nonempty = nonzero || (fill_idx != '0);

  // Gated by reset so upstream never sees a handshake while the block is held in reset.
  assign o_ready = (state == S_FILL) && !i_rst;
  assign o_busy  = !((state == S_FILL) && (fill_idx == '0));

  assign clear_bundle = ((state == S_WAIT) && i_pe_finish && !last_q) || (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (accept) begin
          if (bundle_full || (i_last && bundle_nonempty)) state_nxt = S_ISSUE;
          else if (i_last)                                state_nxt = S_DONE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_pe_finish) state_nxt = last_q ? S_DONE : S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_FILL;
      fill_idx     <= '0;
      last_q       <= 1'b0;
      o_pe_start   <= 1'b0;
      o_tile_done  <= 1'b0;
      o_bundle_cnt <= '0;
      o_pe_addr    <= '0;
      o_pe_w       <= '0;
      o_pe_ia      <= '0;
    end else begin
      state       <= state_nxt;
      o_pe_start  <= (state_nxt == S_ISSUE);
      o_tile_done <= (state_nxt == S_DONE);

      if (accept) begin
        last_q <= i_last;
        if (nonzero) begin
          for (int l = 0; l < LANES; l++) begin
            if (fill_idx == IW'(l)) begin
              o_pe_addr[l*AW +: AW]     <= i_addr;
              o_pe_w[l*DATA_W +: DATA_W]  <= i_w;
              o_pe_ia[l*DATA_W +: DATA_W] <= i_ia;
            end
          end
          fill_idx <= fill_idx + 1'b1;
        end
      end

      if ((state == S_ISSUE) && (o_bundle_cnt != 16'hFFFF))
        o_bundle_cnt <= o_bundle_cnt + 16'd1;

      if (clear_bundle) begin
        fill_idx  <= '0;
        o_pe_addr <= '0;
        o_pe_w    <= '0;
        o_pe_ia   <= '0;
      end

      if (state == S_DONE) begin
        last_q       <= 1'b0;
        o_bundle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_reducer_scheduler.sv
// Bench for pe_reducer_scheduler: directed scenarios plus randomized tiles checked every
// cycle against a transaction-level model of bundle formation and handshake timing.
`timescale 1ns/1ps
module tb_pe_reducer_scheduler;
  localparam int LANES = 3, ADDR_DIMS = 3, ADDR_W = 7, DATA_W = 16;
  localparam int AW = ADDR_DIMS * ADDR_W;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] ia;
  } entry_t;

  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, last = 1'b0, fin = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DATA_W-1:0] w = '0, ia = '0;

  logic                    o_ready, o_pe_start, o_tile_done, o_busy;
  logic [LANES*AW-1:0]     o_pe_addr;
  logic [LANES*DATA_W-1:0] o_pe_w, o_pe_ia;
  logic [15:0]             o_bundle_cnt;

  always #5 clk = ~clk;

  pe_reducer_scheduler #(.LANES(LANES), .ADDR_DIMS(ADDR_DIMS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_last(last),
    .i_addr(addr), .i_w(w), .i_ia(ia), .o_pe_start(o_pe_start), .o_pe_addr(o_pe_addr),
    .o_pe_w(o_pe_w), .o_pe_ia(o_pe_ia), .i_pe_finish(fin), .o_tile_done(o_tile_done),
    .o_bundle_cnt(o_bundle_cnt), .o_busy(o_busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout expected=event", name);
  endtask

  // ---------------- model state ----------------
  entry_t pend[$];
  logic [LANES*AW-1:0]     bexp_addr;
  logic [LANES*DATA_W-1:0] bexp_w, bexp_ia;
  bit blast, start_pend, done_pend, in_wait, just_filled;
  int mcnt;
  int cyc = 0;
  int starts_seen = 0, dones_seen = 0, start_cyc = 0, done_cyc = 0;
  logic [15:0]             done_cnt_seen;
  logic [LANES*AW-1:0]     start_addr_seen;
  logic [LANES*DATA_W-1:0] start_w_seen, start_ia_seen;
  int fin_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit er, eb, was_start, was_done;
    entry_t e;
    if (rst) begin
      chk("rst_ready", o_ready, 0);
      chk("rst_start", o_pe_start, 0);
      chk("rst_done", o_tile_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_bundle_cnt, 0);
      chk("rst_addr", o_pe_addr, 0);
      chk("rst_w", o_pe_w, 0);
      chk("rst_ia", o_pe_ia, 0);
      pend.delete();
      start_pend = 0; done_pend = 0; in_wait = 0; blast = 0; just_filled = 0; mcnt = 0;
    end else begin
      er = !(start_pend || in_wait || done_pend);
      eb = !er || (pend.size() != 0);
      chk("pe_start", o_pe_start, start_pend);
      chk("tile_done", o_tile_done, done_pend);
      chk("ready", o_ready, er);
      chk("busy", o_busy, eb);
      chk("bundle_cnt", o_bundle_cnt, mcnt);
      if (start_pend || in_wait) begin
        chk("bundle_addr", o_pe_addr, bexp_addr);
        chk("bundle_w", o_pe_w, bexp_w);
        chk("bundle_ia", o_pe_ia, bexp_ia);
      end
      if (just_filled) begin
        chk("cleared_addr", o_pe_addr, 0);
        chk("cleared_w", o_pe_w, 0);
        chk("cleared_ia", o_pe_ia, 0);
      end
      just_filled = 0;
      was_start = start_pend;
      was_done  = done_pend;
      start_pend = 0;
      done_pend  = 0;
      if (was_start) begin
        starts_seen++;
        start_cyc = cyc;
        start_addr_seen = o_pe_addr;
        start_w_seen = o_pe_w;
        start_ia_seen = o_pe_ia;
        if (mcnt < 65535) mcnt++;
        in_wait = 1;
      end else if (in_wait && fin) begin
        in_wait = 0;
        if (blast) done_pend = 1;
        else just_filled = 1;
      end
      if (was_done) begin
        dones_seen++;
        done_cyc = cyc;
        done_cnt_seen = o_bundle_cnt;
        mcnt = 0;
        blast = 0;
        just_filled = 1;
      end
      if (er && valid) begin
        e.addr = addr; e.w = w; e.ia = ia;
        if (w != 0 && ia != 0) pend.push_back(e);
        if (pend.size() == LANES || (last && pend.size() != 0)) begin
          bexp_addr = '0; bexp_w = '0; bexp_ia = '0;
          for (int i = 0; i < pend.size(); i++) begin
            bexp_addr[i*AW +: AW]       = pend[i].addr;
            bexp_w[i*DATA_W +: DATA_W]  = pend[i].w;
            bexp_ia[i*DATA_W +: DATA_W] = pend[i].ia;
          end
          blast = last;
          pend.delete();
          start_pend = 1;
        end else if (last) begin
          done_pend = 1;
        end
      end
    end
  end

  // Reducer stand-in: answers each start with a finish pulse according to fin_mode.
  initial forever begin
    @(negedge clk);
    if (o_pe_start && !rst && fin_mode != 2) begin
      if (fin_mode == 1) begin
        #1 fin = 1;
        @(posedge clk); #1 fin = 0;
        repeat (5) @(posedge clk);
        #1 fin = 1;
        @(posedge clk); #1 fin = 0;
      end else begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 fin = 1;
        @(posedge clk); #1 fin = 0;
      end
    end
  end

  function automatic logic [AW-1:0] pa(input int c0, input int c1, input int c2);
    return {ADDR_W'(c2), ADDR_W'(c1), ADDR_W'(c0)};
  endfunction

  // Caller is positioned just after a rising edge.
  task automatic send(input logic [AW-1:0] a, input logic [DATA_W-1:0] wv,
                      input logic [DATA_W-1:0] iv, input bit l);
    int n;
    addr = a; w = wv; ia = iv; last = l; valid = 1;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) timeout_fail("send_handshake");
    @(posedge clk); #1;
    valid = 0; last = 0;
  endtask

  function automatic bit model_idle();
    return !start_pend && !in_wait && !done_pend && !fin;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(posedge clk);
    while (!model_idle() && n < 300) begin
      n++;
      @(posedge clk);
    end
    if (!model_idle()) timeout_fail(name);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, n;
    logic [DATA_W-1:0] rw, ri;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // full bundle, then close the tile with an all-zero last entry
    send(pa(0, 0, 0), 16'd15, 16'd3, 0);
    send(pa(1, 1, 1), 16'd16, 16'd2, 0);
    send(pa(2, 2, 2), 16'd17, 16'd1, 0);
    send(pa(9, 9, 9), 16'd0, 16'd0, 1);
    wait_idle("t1_idle");
    chk("t1_w", start_w_seen, 48'h0011_0010_000F);
    chk("t1_ia", start_ia_seen, 48'h0001_0002_0003);
    chk("t1_addr", start_addr_seen, {pa(2, 2, 2), pa(1, 1, 1), pa(0, 0, 0)});
    chk("t1_cnt", done_cnt_seen, 1);

    // partial flush
    send(pa(2, 2, 2), 16'd4, 16'd3, 0);
    send(pa(3, 3, 3), 16'd6, 16'd1, 1);
    wait_idle("t2_idle");
    chk("t2_w", start_w_seen, 48'h0000_0006_0004);
    chk("t2_addr", start_addr_seen, {pa(0, 0, 0), pa(3, 3, 3), pa(2, 2, 2)});
    chk("t2_cnt", done_cnt_seen, 1);

    // zero skip, then an all-zero tile
    send(pa(1, 2, 3), 16'd0, 16'd5, 0);
    send(pa(1, 2, 3), 16'd7, 16'd0, 0);
    send(pa(4, 5, 6), 16'd2, 16'd9, 1);
    wait_idle("t3_idle");
    chk("t3_w", start_w_seen, 48'h0000_0000_0002);
    chk("t3_ia", start_ia_seen, 48'h0000_0000_0009);
    chk("t3_cnt", done_cnt_seen, 1);
    s0 = starts_seen; d0 = dones_seen;
    send(pa(1, 1, 1), 16'd0, 16'd0, 0);
    send(pa(1, 1, 1), 16'd0, 16'hFFFD, 1);
    wait_idle("t3z_idle");
    chk("t3z_starts", starts_seen - s0, 0);
    chk("t3z_dones", dones_seen - d0, 1);
    chk("t3z_cnt", done_cnt_seen, 0);

    // finish during ISSUE is ignored; bundle held through a long WAIT
    fin_mode = 1;
    send(pa(5, 0, 0), 16'hFFFF, 16'd8, 0);
    send(pa(6, 0, 0), 16'h8000, 16'h7FFF, 0);
    send(pa(7, 0, 0), 16'd3, 16'hFFF0, 1);
    wait_idle("t4_idle");
    fin_mode = 0;
    chk("t4_latency", done_cyc - start_cyc, 7);
    chk("t4_w", start_w_seen, 48'h0003_8000_FFFF);

    // multi-bundle tile
    s0 = starts_seen;
    for (int i = 0; i < 7; i++) send(pa(i, i + 1, i + 2), DATA_W'(i + 1), DATA_W'(10 * i + 1), i == 6);
    wait_idle("t5_idle");
    chk("t5_starts", starts_seen - s0, 3);
    chk("t5_cnt", done_cnt_seen, 3);
    chk("t5_lastw", start_w_seen, 48'h0000_0000_0007);
    @(negedge clk);
    chk("t5_cnt_after", o_bundle_cnt, 0);
    @(posedge clk); #1;

    // reset in the middle of WAIT
    fin_mode = 2;
    send(pa(1, 0, 0), 16'd1, 16'd1, 0);
    send(pa(2, 0, 0), 16'd2, 16'd2, 0);
    send(pa(3, 0, 0), 16'd3, 16'd3, 0);
    n = 0;
    while (!in_wait && n < 50) begin
      n++;
      @(posedge clk);
    end
    if (!in_wait) timeout_fail("t6_wait");
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t6_w_now", o_pe_w, 0);
    chk("t6_busy_now", o_busy, 0);
    chk("t6_ready_now", o_ready, 0);
    @(posedge clk); #1 rst = 0;
    s0 = starts_seen; d0 = dones_seen;
    fin_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_start", starts_seen - s0, 0);
    chk("t6_no_done", dones_seen - d0, 0);
    chk("t6_ready", o_ready, 1);

    // randomized tiles
    for (int i = 0; i < 400; i++) begin
      rw = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      ri = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      send(AW'($urandom), rw, ri, ($urandom_range(0, 6) == 0) || (i == 399));
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    wait_idle("rand_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_reducer_scheduler.md
Name: pe_reducer_scheduler

Overview:
- Feeds the PE reducer from a serial stream of compressed (address, weight, activation) entries.
- Drops zero products and packs survivors into LANES-wide bundles.
- Pulses the reducer start for each bundle, then holds the bundle stable until the reducer reports finish.
- Flushes a partial bundle at end of tile and signals tile completion upstream.

Parameters:
LANES, 3, number of reducer lanes per bundle
ADDR_DIMS, 3, address coordinates per entry
ADDR_W, 7, bits per address coordinate
DATA_W, 16, signed weight/activation width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  upstream entry valid
o_ready  out  1  scheduler can accept an entry
i_last  in  1  entry is the last of the current tile
i_addr  in  ADDR_DIMS*ADDR_W  entry address coordinates
i_w  in  DATA_W  signed weight
i_ia  in  DATA_W  signed input activation
o_pe_start  out  1  one-cycle start pulse to the reducer
o_pe_addr  out  LANES*ADDR_DIMS*ADDR_W  bundled addresses, lane 0 in LSBs
o_pe_w  out  LANES*DATA_W  bundled weights
o_pe_ia  out  LANES*DATA_W  bundled activations
i_pe_finish  in  1  reducer done with the current bundle
o_tile_done  out  1  one-cycle pulse when a tile is fully reduced
o_bundle_cnt  out  16  bundles issued in the current or last tile
o_busy  out  1  high in every state except FILL with an empty bundle

Behaviour:
- States: FILL, ISSUE, WAIT, DONE. Reset state is FILL.
- Reset (async, i_rst=1) clears state, fill index, last flag, bundle registers and all outputs to 0; o_ready is 0 during reset. A reset asserted mid-WAIT abandons the bundle; no start or done is issued afterwards.
- Accept: an entry is accepted when i_valid && o_ready. o_ready=1 only in FILL.
- Zero skip: an accepted entry with i_w==0 or i_ia==0 is consumed but not placed into the bundle. Its i_last still takes effect.
- Placement: a non-zero entry is written to lane fill_idx, then fill_idx increments.
- FILL -> ISSUE when an accept fills lane LANES-1, or when an accepted entry has i_last=1 and the bundle, including this entry, is non-empty. The last flag is latched from i_last.
- FILL -> DONE when an accepted entry has i_last=1 and the bundle is empty (all entries of the tile were zero or already issued). No start is issued.
- Padding: unfilled lanes present addr=0, w=0, ia=0.
- ISSUE: o_pe_start=1 for exactly this cycle. o_bundle_cnt increments, saturating at 16'hFFFF. Next state is WAIT unconditionally.
- Latency: the third accept at cycle t gives o_pe_start high at cycle t+1.
- WAIT: o_pe_start=0. i_pe_finish is sampled only in WAIT; finish during ISSUE is ignored.
  - On finish with the last flag set -> DONE.
  - On finish otherwise -> FILL, with fill_idx cleared.
- Bundle hold: o_pe_* are registered and hold constant from ISSUE through the finish cycle. They clear to 0 on the transition back to FILL.
- DONE: o_tile_done=1 for one cycle; o_bundle_cnt is valid during this pulse. Next state is FILL; on that transition the last flag and o_bundle_cnt clear.
- No accept occurs while in ISSUE, WAIT or DONE. Upstream must hold i_valid and data stable until accepted.
- Products are not computed here. Widths pass through unchanged and signed values are not altered.

Test Plan:
- Full bundle: accept (addr 0,0,0 w15 ia3), (1,1,1 w16 ia2), (2,2,2 w17 ia1) on consecutive cycles -> o_pe_start one cycle after third accept; lanes hold exactly those values; o_ready=0 until i_pe_finish.
- Partial flush: accept (2,2,2 w4 ia3), then (3,3,3 w6 ia1, i_last=1) -> start with lanes 0/1 filled and lane 2 all-zero. After finish -> o_tile_done pulse with o_bundle_cnt=1.
- Zero skip: accept w=0 ia=5, then w=7 ia=0, then w=2 ia=9 with i_last=1 -> single bundle with only lane 0 = (w2, ia9). All-zero tile with i_last -> o_tile_done with no o_pe_start and o_bundle_cnt=0.
- Early finish: drive i_pe_finish=1 in the ISSUE cycle, then hold it low 5 cycles -> scheduler stays in WAIT with bundle stable; it advances only on a later finish.
- Multi-bundle tile: 7 non-zero entries, last on the 7th -> three starts (3,3,1 lanes); o_bundle_cnt=3 at o_tile_done; the counter reads 0 the cycle after.
- Reset mid-WAIT: assert i_rst during WAIT -> all outputs 0 immediately, state FILL after release, no spurious o_pe_start or o_tile_done.
